// File: rtl/slice_add_sequencer_if.sv
// Handshake and slice bus bundle for slice_add_sequencer.
// The slave modport is the sequencer; the master modport is the producer/consumer/slice side.
interface slice_add_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int SLICE = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic             slice_cin;
  logic [SLICE-1:0] slice_s;
  logic [SLICE-1:0] slice_c;

  modport slave (
    input  in_valid, a, b, c_in, out_ready, slice_s, slice_c,
    output in_ready, out_valid, sum, c_out, busy, slice_a, slice_b, slice_cin
  );

  modport master (
    output in_valid, a, b, c_in, out_ready, slice_s, slice_c,
    input  in_ready, out_valid, sum, c_out, busy, slice_a, slice_b, slice_cin
  );
endinterface

// File: rtl/slice_add_sequencer.sv
// Multi-cycle WIDTH-bit adder that time-shares one external SLICE-bit ripple slice,
// walking the operands LSB chunk first with the inter-chunk carry held in a register.
module slice_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  slice_add_sequencer_if.slave bus
);

  localparam int NCHUNK = (WIDTH + SLICE - 1) / SLICE;
  localparam int R      = WIDTH - (NCHUNK - 1) * SLICE;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nx_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   sum_r;
  logic [WIDTH-1:0]   sum_nx_s;
  logic               carry_r;
  logic               c_out_r;
  logic [IDX_W-1:0]   idx_r;
  logic [SLICE-1:0]   slice_a_s;
  logic [SLICE-1:0]   slice_b_s;
  logic               run_s;
  logic               last_s;

  assign run_s  = (state_r == ST_RUN);
  assign last_s = (idx_r == IDX_W'(NCHUNK - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) state_nx_s = ST_RUN;
        else              state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_nx_s = ST_DONE;
        else        state_nx_s = ST_RUN;
      end
      ST_DONE: begin
        if (bus.out_ready) state_nx_s = ST_IDLE;
        else               state_nx_s = ST_DONE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Chunk select toward the slice and in-place merge of the returned sum chunk.
  // Bits above WIDTH in the top chunk never exist here, so zero-extension and
  // top-chunk truncation both fall out of iterating over real operand bits only.
  always_comb begin : chunk_mux
    logic hit_v;
    hit_v     = 1'b0;
    slice_a_s = '0;
    slice_b_s = '0;
    sum_nx_s  = sum_r;
    for (int j = 0; j < WIDTH; j++) begin
      hit_v = run_s && (idx_r == IDX_W'(j / SLICE));
      slice_a_s[j % SLICE] = slice_a_s[j % SLICE] | (a_r[j] & hit_v);
      slice_b_s[j % SLICE] = slice_b_s[j % SLICE] | (b_r[j] & hit_v);
      sum_nx_s[j]          = hit_v ? bus.slice_s[j % SLICE] : sum_r[j];
    end
  end

  // Operand capture, per-chunk accumulation and carry chaining
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      c_out_r <= 1'b0;
      idx_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            carry_r <= bus.c_in;
            idx_r   <= '0;
          end
        end
        ST_RUN: begin
          sum_r   <= sum_nx_s;
          carry_r <= bus.slice_c[SLICE-1];
          idx_r   <= idx_r + IDX_W'(1);
          // The final carry comes from the top real bit, not the top slice bit.
          if (last_s) c_out_r <= bus.slice_c[R-1];
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == ST_IDLE);
  assign bus.out_valid = (state_r == ST_DONE);
  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.sum       = sum_r;
  assign bus.c_out     = c_out_r;
  assign bus.slice_a   = slice_a_s;
  assign bus.slice_b   = slice_b_s;
  assign bus.slice_cin = run_s & carry_r;

endmodule
